// File: rtl/dm_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states,
// byte-enable merge, illegal-access flagging and a one-cycle store log record.
module dm_responder #(
    parameter int DEPTH       = 3072,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    input  logic [31:0] req_pc,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        log_valid,
    output logic [31:0] log_pc,
    output logic [31:0] log_addr,
    output logic [31:0] log_data
);
    localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
    localparam logic [31:0] ADDR_LIMIT = 32'(DEPTH * 4);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   pc_q, pc_d;
    logic          resp_valid_q, resp_valid_d;
    logic [31:0]   resp_rdata_q, resp_rdata_d;
    logic          resp_err_q, resp_err_d;
    logic          log_valid_q, log_valid_d;
    logic [31:0]   log_pc_q, log_pc_d;
    logic [31:0]   log_addr_q, log_addr_d;
    logic [31:0]   log_data_q, log_data_d;
    logic [31:0]   mem_q [DEPTH];

    logic          accept, commit, legal, in_range;
    logic          c_we;
    logic [31:0]   c_addr, c_wdata, c_pc;
    logic [3:0]    c_be;
    logic [AW-1:0] idx;
    logic [31:0]   old_word, merged;

    // State register plus all captured/response flops and the memory array.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            pc_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            log_valid_q  <= 1'b0;
            log_pc_q     <= '0;
            log_addr_q   <= '0;
            log_data_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            pc_q         <= pc_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            log_valid_q  <= log_valid_d;
            log_pc_q     <= log_pc_d;
            log_addr_q   <= log_addr_d;
            log_data_q   <= log_data_d;
            if (log_valid_d) mem_q[idx] <= merged;
        end
    end

    // Next-state logic; commit marks the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: if (req_valid) begin
                accept = 1'b1;
                if (WAIT_CYCLES == 0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: if (cnt_q == '0) begin
                state_d = RESP;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            RESP: if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: with zero wait states the commit uses the live request.
    always_comb begin
        we_d    = accept ? req_we    : we_q;
        addr_d  = accept ? req_addr  : addr_q;
        be_d    = accept ? req_be    : be_q;
        wdata_d = accept ? req_wdata : wdata_q;
        pc_d    = accept ? req_pc    : pc_q;

        c_we    = (state_q == IDLE) ? req_we    : we_q;
        c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        c_be    = (state_q == IDLE) ? req_be    : be_q;
        c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        c_pc    = (state_q == IDLE) ? req_pc    : pc_q;

        in_range = (c_addr < ADDR_LIMIT);
        case ({c_be, c_addr[1:0]})
            6'b1111_00, 6'b0011_00, 6'b1100_10, 6'b0001_00,
            6'b0010_01, 6'b0100_10, 6'b1000_11: legal = in_range;
            default:                            legal = 1'b0;
        endcase

        idx      = c_addr[AW+1:2];
        old_word = in_range ? mem_q[idx] : '0;
        merged   = old_word;
        for (int i = 0; i < 4; i++)
            if (c_be[i]) merged[8*i +: 8] = c_wdata[8*i +: 8];

        resp_valid_d = (state_d == RESP);
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (commit) begin
            resp_rdata_d = (legal && !c_we) ? old_word : '0;
            resp_err_d   = !legal;
        end

        log_valid_d = commit && legal && c_we;
        log_pc_d    = log_valid_d ? c_pc : log_pc_q;
        log_addr_d  = log_valid_d ? {c_addr[31:2], 2'b00} : log_addr_q;
        log_data_d  = log_valid_d ? merged : log_data_q;
    end

    // Output logic.
    always_comb begin
        req_ready  = (state_q == IDLE) && !reset;
        resp_valid = resp_valid_q;
        resp_rdata = resp_rdata_q;
        resp_err   = resp_err_q;
        log_valid  = log_valid_q;
        log_pc     = log_pc_q;
        log_addr   = log_addr_q;
        log_data   = log_data_q;
    end
endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a WAIT_CYCLES=2 instance for the main
// scenarios and a WAIT_CYCLES=0 instance for the back-to-back stream.
module tb_dm_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, log_valid;
    logic [31:0] req_addr, req_wdata, req_pc, resp_rdata, log_pc, log_addr, log_data;
    logic [3:0]  req_be;

    logic        z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err, z_log_valid;
    logic [31:0] z_req_addr, z_req_wdata, z_req_pc, z_resp_rdata, z_log_pc, z_log_addr, z_log_data;
    logic [3:0]  z_req_be;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(3072), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
        .req_pc(req_pc), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err), .log_valid(log_valid),
        .log_pc(log_pc), .log_addr(log_addr), .log_data(log_data));

    dm_responder #(.DEPTH(3072), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .req_ready(z_req_ready),
        .req_we(z_req_we), .req_addr(z_req_addr), .req_be(z_req_be), .req_wdata(z_req_wdata),
        .req_pc(z_req_pc), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .log_valid(z_log_valid),
        .log_pc(z_log_pc), .log_addr(z_log_addr), .log_data(z_log_data));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One transaction on the WAIT=2 instance; entered and left at posedge+1.
    task automatic xact(input logic we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wdata, input logic [31:0] pc,
                        output logic [31:0] rdata, output logic err, output int lat,
                        output int nlog, output logic [31:0] lpc, output logic [31:0] laddr,
                        output logic [31:0] ldata);
        bit done = 0;
        req_valid = 1; req_we = we; req_addr = addr; req_be = be; req_wdata = wdata; req_pc = pc;
        lat = 0; nlog = 0; rdata = 0; err = 0; lpc = 0; laddr = 0; ldata = 0;
        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (log_valid) begin nlog++; lpc = log_pc; laddr = log_addr; ldata = log_data; end
            if (resp_valid) begin done = 1; rdata = resp_rdata; err = resp_err; end
        end
        if (!done) chk("resp_timeout", 0, 1);
        @(posedge clk); #1;
        @(negedge clk);
        if (log_valid) nlog++;
        chk("resp_dropped", resp_valid, 0);
        @(posedge clk); #1;
    endtask

    logic [31:0] rd, lpc, laddr, ldata;
    logic        er;
    int          lat, nlog;

    logic [31:0] z_addr [6];
    logic [31:0] z_data [6];
    logic [31:0] z_exp  [6];
    logic [3:0]  z_be   [6];
    logic        z_we   [6];

    initial begin
        reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_be = 0; req_wdata = 0;
        req_pc = 0; resp_ready = 1;
        z_req_valid = 0; z_req_we = 0; z_req_addr = 0; z_req_be = 0; z_req_wdata = 0;
        z_req_pc = 0; z_resp_ready = 1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_log_valid", log_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_log_data", log_data, 0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("post_rst_ready", req_ready, 1);
        @(posedge clk); #1;

        // sw 0x10
        xact(1, 32'h10, 4'b1111, 32'h12345678, 32'h3000, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("sw_latency", lat, 3);
        chk("sw_err", er, 0);
        chk("sw_rdata", rd, 0);
        chk("sw_nlog", nlog, 1);
        chk("sw_log_pc", lpc, 32'h3000);
        chk("sw_log_addr", laddr, 32'h10);
        chk("sw_log_data", ldata, 32'h12345678);

        xact(0, 32'h10, 4'b1111, 0, 32'h3004, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("lw_latency", lat, 3);
        chk("lw_rdata", rd, 32'h12345678);
        chk("lw_nlog", nlog, 0);

        xact(1, 32'h11, 4'b0010, 32'h0000AB00, 32'h3008, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("sb_err", er, 0);
        chk("sb_log_addr", laddr, 32'h10);
        chk("sb_log_data", ldata, 32'h1234AB78);

        xact(1, 32'h12, 4'b1100, 32'hBEEF0000, 32'h300C, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("sh_log_pc", lpc, 32'h300C);
        chk("sh_log_addr", laddr, 32'h10);
        chk("sh_log_data", ldata, 32'hBEEFAB78);

        xact(1, 32'h12, 4'b1111, 32'hDEADDEAD, 32'h3010, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("misalign_err", er, 1);
        chk("misalign_rdata", rd, 0);
        chk("misalign_nlog", nlog, 0);

        xact(0, 32'h10, 4'b1111, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("unchanged_rdata", rd, 32'hBEEFAB78);
        chk("unchanged_err", er, 0);

        xact(0, 32'h13, 4'b1000, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("lb_err", er, 0);
        chk("lb_rdata", rd, 32'hBEEFAB78);

        xact(0, 32'h10, 4'b0000, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("be0_err", er, 1);
        chk("be0_rdata", rd, 0);

        xact(0, 32'h3000, 4'b1111, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("oob_err", er, 1);
        chk("oob_rdata", rd, 0);

        xact(1, 32'h2FFC, 4'b1111, 32'h5A5A5A5A, 32'h3014, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("last_sw_err", er, 0);
        chk("last_sw_nlog", nlog, 1);
        xact(0, 32'h2FFC, 4'b1111, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("last_lw_rdata", rd, 32'h5A5A5A5A);

        // Response stall: hold resp_ready low for 5 cycles in RESP
        resp_ready = 0;
        req_valid = 1; req_we = 1; req_addr = 32'h14; req_be = 4'b1111;
        req_wdata = 32'hCAFEF00D; req_pc = 32'h3020;
        @(posedge clk); #1;
        req_valid = 0;
        nlog = 0; lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clk); lat++;
            if (log_valid) nlog++;
        end
        chk("stall_latency", lat, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (log_valid) nlog++;
            chk("stall_valid", resp_valid, 1);
            chk("stall_rdata", resp_rdata, 0);
            chk("stall_err", resp_err, 0);
            chk("stall_req_ready", req_ready, 0);
        end
        resp_ready = 1;
        @(negedge clk);
        if (log_valid) nlog++;
        chk("stall_released", resp_valid, 0);
        chk("stall_ready_back", req_ready, 1);
        chk("stall_nlog", nlog, 1);
        @(posedge clk); #1;
        xact(0, 32'h14, 4'b1111, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("stall_lw_rdata", rd, 32'hCAFEF00D);

        // Reset while BUSY with a store outstanding
        req_valid = 1; req_we = 1; req_addr = 32'h20; req_be = 4'b1111;
        req_wdata = 32'hFFFFFFFF; req_pc = 32'h3030;
        @(posedge clk); #1;
        req_valid = 0;
        reset = 1;
        @(negedge clk);
        chk("midrst_req_ready", req_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        nlog = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (log_valid || resp_valid) nlog++;
        end
        chk("midrst_no_activity", nlog, 0);
        @(posedge clk); #1;
        xact(0, 32'h20, 4'b1111, 0, 0, rd, er, lat, nlog, lpc, laddr, ldata);
        chk("midrst_lw_rdata", rd, 0);
        chk("midrst_lw_err", er, 0);

        // Zero-wait-state instance: back-to-back stream
        z_we[0] = 1; z_addr[0] = 32'h40; z_be[0] = 4'b1111; z_data[0] = 32'h11112222; z_exp[0] = 0;
        z_we[1] = 1; z_addr[1] = 32'h44; z_be[1] = 4'b1111; z_data[1] = 32'h33334444; z_exp[1] = 0;
        z_we[2] = 0; z_addr[2] = 32'h40; z_be[2] = 4'b1111; z_data[2] = 0; z_exp[2] = 32'h11112222;
        z_we[3] = 0; z_addr[3] = 32'h44; z_be[3] = 4'b1111; z_data[3] = 0; z_exp[3] = 32'h33334444;
        z_we[4] = 1; z_addr[4] = 32'h47; z_be[4] = 4'b1000; z_data[4] = 32'hAA000000; z_exp[4] = 0;
        z_we[5] = 0; z_addr[5] = 32'h44; z_be[5] = 4'b1111; z_data[5] = 0; z_exp[5] = 32'hAA334444;
        begin
            int  iss = 0;
            int  rsp = 0;
            int  cyc = 0;
            bit  acc;
            z_req_valid = 1; z_req_we = z_we[0]; z_req_addr = z_addr[0];
            z_req_be = z_be[0]; z_req_wdata = z_data[0]; z_req_pc = 32'h4000;
            while (rsp < 6 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (z_resp_valid) begin
                    chk("z_rdata", z_resp_rdata, z_exp[rsp]);
                    chk("z_err", z_resp_err, 0);
                    rsp++;
                end
                acc = z_req_ready && z_req_valid;
                @(posedge clk); #1;
                if (acc) begin
                    iss++;
                    if (iss < 6) begin
                        z_req_we = z_we[iss]; z_req_addr = z_addr[iss]; z_req_be = z_be[iss];
                        z_req_wdata = z_data[iss]; z_req_pc = 32'h4000 + 32'(iss * 4);
                    end else begin
                        z_req_valid = 0;
                    end
                end
            end
            chk("z_responses", rsp, 6);
            chk("z_cycles", cyc, 12);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
